reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file with a write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 32x32 two-read-port register file in the pipelined CPU datapath. It sits between decode, which reads operands and issues destinations, and writeback, which retires results. Decode uses the busy flags to stall on RAW hazards; writeback results reach same-cycle readers through the bypass.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports
- SP_IDX, 29, index of the stack-pointer register
- SP_RST, 124, reset value of register SP_IDX

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- rd_addr_i  in  N_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  N_RD*DATA_W  read data, packed the same way as rd_addr_i
- rd_busy_o  out  N_RD  port k's register has an unretired pending write
- we_i  in  1  writeback valid
- wa_i  in  ADDR_W  writeback address
- wd_i  in  DATA_W  writeback data
- iss_i  in  1  issue: mark iss_addr_i as pending
- iss_addr_i  in  ADDR_W  destination register of the issuing instruction
- flush_i  in  1  clear all pending bits; register contents are unaffected
- pend_o  out  2**ADDR_W  raw scoreboard vector, for debug and verification

## Operation
- **Reset (rst_i=0, asynchronous):**
  - all registers = 0, except register SP_IDX = SP_RST
  - all pending bits = 0
  - rd_busy_o = 0; pend_o = 0; rd_data_o shows reset contents (SP_RST on any port addressing SP_IDX, 0 otherwise)
- **Register 0:**
  - always reads 0 and is never busy
  - writes to it are dropped; issues to it are dropped
- **Write:** on a clock edge with we_i=1 and wa_i≠0, reg[wa_i] ← wd_i.
- **Bypass:** for each port k, if we_i=1, wa_i≠0 and rd_addr k = wa_i:
  - rd_data k = wd_i
  - rd_busy k = 0, unless iss_i=1 with iss_addr_i = wa_i and flush_i=0
- **Read, otherwise:** rd_data k = reg[rd_addr k]; rd_busy k = pend[rd_addr k].
- **Scoreboard next state**, per register r≠0, evaluated in priority order:
  1. flush_i=1 → pend[r]=0. Any issue in the same cycle is ignored.
  2. iss_i=1 and iss_addr_i=r → pend[r]=1. This wins over a same-cycle writeback to r, because the new producer supersedes the old one.
  3. we_i=1 and wa_i=r → pend[r]=0.
  4. otherwise pend[r] holds.
- Writeback to a register that is not pending is legal: data is written and pend stays 0.
- Reissue to a register that is already pending is legal: pend stays 1. A single bit tracks only the youngest producer; in-order writeback is required of the pipeline.
- Read ports are independent. Any number of ports may address the same register.

## Timing
- Reads are combinational. Address-to-data is a single cycle with zero latency; there is no read register.
- A write is visible through the bypass in the same cycle. It is visible from the array from the next cycle onward.
- An issue at edge n makes rd_busy=1 from cycle n+1.
- A writeback in cycle n makes rd_busy=0 in cycle n (through the bypass) and in every later cycle (through the array).
- flush_i acts at the edge. The pending vector is all-zero from the following cycle.
- Reset asserted mid-operation clears state immediately, regardless of clk_i. Deassertion is taken synchronously by upstream logic; the block needs no reset synchroniser.

## Structure
- The shared CPU package holds:
  - default DATA_W and ADDR_W
  - SP_IDX and SP_RST
  - the zero-register index
- One sub-module, reg_file_sb_port: a single read port containing the bypass and busy mux, instantiated N_RD times by a generate loop.
- The storage array and scoreboard stay in the top module.

## Test plan
- **Reset:** assert rst_i=0 mid-run with no clock edges.
  - port 0 reads addr 29 → 124; port 1 reads addr 5 → 0
  - pend_o=0; rd_busy_o=0
- **Write/bypass:** we_i=1, wa_i=7, wd_i=0xDEADBEEF, port 0 reads 7.
  - same cycle: rd_data=0xDEADBEEF
  - next cycle with we_i=0: still 0xDEADBEEF
- **Zero register:** write 0x1234 to r0 and issue r0.
  - r0 reads 0; pend_o[0]=0; rd_busy=0
- **Scoreboard:** issue r3, hold 3 cycles, then writeback r3=0x55.
  - rd_busy for r3 = 1 on cycles 1-3
  - 0 in the writeback cycle, with data 0x55
- **Simultaneous events:**
  - issue r3 plus writeback r3 in the same cycle → pend[3]=1 next cycle
  - flush plus issue r4 in the same cycle → pend_o=0 next cycle
- **N_RD=4, DATA_W=64:** all four ports read distinct, overlapping and bypassed addresses.
  - every port matches the reference model for every cycle of a 10k-cycle random run

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared CPU register-file constants: default geometry, stack-pointer
// location and reset value, and the hard-wired zero register index.
package reg_file_sb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int SP_IDX_DEF = 29;
   localparam int SP_RST_DEF = 124;
   localparam int ZERO_IDX   = 0;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_port.sv
// One combinational read port. A same-cycle writeback to the addressed
// register is forwarded ahead of the array. The forwarded value is only
// busy when a new producer for that register issues in the same cycle.
module reg_file_sb_port
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
   input  logic [DEPTH-1:0]             pend_i,
   input  logic [ADDR_W-1:0]            rd_addr_i,
   input  logic                         wr_en_i,
   input  logic [ADDR_W-1:0]            wa_i,
   input  logic [DATA_W-1:0]            wd_i,
   input  logic                         wr_reissue_i,
   output logic [DATA_W-1:0]            rd_data_o,
   output logic                         rd_busy_o
);

   // Bypass mux first, then array read; register 0 is forced to zero and idle.
   always_comb begin
      rd_data_o = regs_i[rd_addr_i];
      rd_busy_o = pend_i[rd_addr_i];
      if (rd_addr_i == ADDR_W'(ZERO_IDX)) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end else if (wr_en_i && (rd_addr_i == wa_i)) begin
         rd_data_o = wd_i;
         rd_busy_o = wr_reissue_i;
      end
   end

endmodule : reg_file_sb_port

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-to-read bypass and a pending-write
// scoreboard used by decode to stall on RAW hazards.
// pend_o exposes the raw scoreboard vector for debug.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int N_RD   = 2,
   parameter int SP_IDX = SP_IDX_DEF,
   parameter int SP_RST = SP_RST_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
   output logic [N_RD*DATA_W-1:0]   rd_data_o,
   output logic [N_RD-1:0]          rd_busy_o,
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        wa_i,
   input  logic [DATA_W-1:0]        wd_i,
   input  logic                     iss_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   input  logic                     flush_i,
   output logic [2**ADDR_W-1:0]     pend_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]             pend_q, pend_d;
   logic                         wr_en;
   logic                         iss_en;
   logic                         wr_reissue;

   // Writes and issues aimed at register 0 are dropped here, once for all users.
   assign wr_en      = we_i  && (wa_i       != ADDR_W'(ZERO_IDX));
   assign iss_en     = iss_i && (iss_addr_i != ADDR_W'(ZERO_IDX));
   assign wr_reissue = iss_en && !flush_i && (iss_addr_i == wa_i);

   // Storage next state: single write port.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wa_i] = wd_i;
   end

   // Scoreboard next state: flush beats issue, issue beats retiring writeback.
   always_comb begin
      pend_d = pend_q;
      if (flush_i) begin
         pend_d = '0;
      end else begin
         if (wr_en)  pend_d[wa_i]       = 1'b0;
         if (iss_en) pend_d[iss_addr_i] = 1'b1;
      end
   end

   // State registers; reset loads zeros except the stack pointer.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
         end
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      reg_file_sb_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_port (
         .regs_i       (regs_q),
         .pend_i       (pend_q),
         .rd_addr_i    (rd_addr_i[k*ADDR_W +: ADDR_W]),
         .wr_en_i      (wr_en),
         .wa_i         (wa_i),
         .wd_i         (wd_i),
         .wr_reissue_i (wr_reissue),
         .rd_data_o    (rd_data_o[k*DATA_W +: DATA_W]),
         .rd_busy_o    (rd_busy_o[k])
      );
   end

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb with four 64-bit read ports: directed vectors with
// hand-computed expectations, then a long random run against a behavioural
// model. Expectations are queued per cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_reg_file_sb;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 4;

   typedef struct {
      string             name;
      logic [NR-1:0]     dmask;
      logic [NR-1:0]     bmask;
      logic              pchk;
      logic [DW-1:0]     d [NR];
      logic [NR-1:0]     b;
      logic [31:0]       p;
   } exp_t;

   // clock/reset block
   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic rst_n = 1'b0;
   always #5 clk = clk_en ? ~clk : 1'b0;

   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             we, iss, flush;
   logic [AW-1:0]    wa, ia;
   logic [DW-1:0]    wd;
   logic [31:0]      pend;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .SP_IDX(29), .SP_RST(124)) dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_busy_o  (rd_busy),
      .we_i       (we),
      .wa_i       (wa),
      .wd_i       (wd),
      .iss_i      (iss),
      .iss_addr_i (ia),
      .flush_i    (flush),
      .pend_o     (pend)
   );

   // reference model state
   logic [DW-1:0] m_regs [32];
   logic [31:0]   m_pend;

   exp_t exp_q[$];
   exp_t cur;
   event sample_ev;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_regs[29] = 64'd124;
      m_pend = '0;
   endtask

   task automatic model_update();
      logic w_ok, i_ok;
      w_ok = we && (wa != 0);
      i_ok = iss && (ia != 0);
      if (flush) m_pend = '0;
      else begin
         if (w_ok) m_pend[wa] = 1'b0;
         if (i_ok) m_pend[ia] = 1'b1;
      end
      if (w_ok) m_regs[wa] = wd;
   endtask

   // Expected outputs for the current inputs derived from the model.
   task automatic model_expect();
      logic [AW-1:0] a;
      for (int k = 0; k < NR; k++) begin
         a = rd_addr[k*AW +: AW];
         cur.dmask[k] = 1'b1;
         cur.bmask[k] = 1'b1;
         if (a == 0) begin
            cur.d[k] = '0;
            cur.b[k] = 1'b0;
         end else if (we && (wa == a)) begin
            cur.d[k] = wd;
            cur.b[k] = iss && !flush && (ia == a);
         end else begin
            cur.d[k] = m_regs[a];
            cur.b[k] = m_pend[a];
         end
      end
      cur.pchk = 1'b1;
      cur.p    = m_pend;
   endtask

   // driver tasks
   task automatic begin_cycle(input string nm);
      @(negedge clk);
      cur.name  = nm;
      cur.dmask = '0;
      cur.bmask = '0;
      cur.pchk  = 1'b0;
      we = 0; wa = 0; wd = 0; iss = 0; ia = 0; flush = 0;
      rd_addr = '0;
   endtask

   task automatic set_ra(input int k, input logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask

   task automatic exp_port(input int k, input logic [DW-1:0] d, input logic b);
      cur.dmask[k] = 1'b1;
      cur.bmask[k] = 1'b1;
      cur.d[k]     = d;
      cur.b[k]     = b;
   endtask

   task automatic exp_pend(input logic [31:0] p);
      cur.pchk = 1'b1;
      cur.p    = p;
   endtask

   task automatic end_cycle();
      exp_q.push_back(cur);
      #1 -> sample_ev;
      @(posedge clk);
      model_update();
   endtask

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
      return AW'($urandom_range(0, 7));
   endfunction

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL monitor: sample with no expectation queued (got 0 entries, want 1)");
         end else begin
            n_cmp--;
            e = exp_q.pop_front();
            for (int k = 0; k < NR; k++) begin
               if (e.dmask[k]) begin
                  n_cmp++;
                  if (rd_data[k*DW +: DW] !== e.d[k]) begin
                     n_bad++;
                     $display("FAIL %s port%0d data: got %h want %h", e.name, k, rd_data[k*DW +: DW], e.d[k]);
                  end
               end
               if (e.bmask[k]) begin
                  n_cmp++;
                  if (rd_busy[k] !== e.b[k]) begin
                     n_bad++;
                     $display("FAIL %s port%0d busy: got %b want %b", e.name, k, rd_busy[k], e.b[k]);
                  end
               end
            end
            if (e.pchk) begin
               n_cmp++;
               if (pend !== e.p) begin
                  n_bad++;
                  $display("FAIL %s pend: got %h want %h", e.name, pend, e.p);
               end
            end
         end
      end
   end

   // watchdog
   initial begin
      #3_000_000;
      n_bad++;
      $display("FAIL watchdog: run did not complete (got timeout, want finish)");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      we = 0; wa = 0; wd = 0; iss = 0; ia = 0; flush = 0; rd_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // write with same-cycle bypass, then array read
      begin_cycle("wr_bypass");
      we = 1; wa = 7; wd = 64'hDEADBEEF; set_ra(0, 7);
      exp_port(0, 64'hDEADBEEF, 0); exp_pend(32'h0);
      end_cycle();
      begin_cycle("wr_array");
      for (int k = 0; k < NR; k++) set_ra(k, 7);
      for (int k = 0; k < NR; k++) exp_port(k, 64'hDEADBEEF, 0);
      end_cycle();

      // register 0: write and issue dropped
      begin_cycle("r0_wr_iss");
      we = 1; wa = 0; wd = 64'h1234; iss = 1; ia = 0; set_ra(0, 0);
      exp_port(0, 64'h0, 0); exp_pend(32'h0);
      end_cycle();
      begin_cycle("r0_after");
      set_ra(0, 0);
      exp_port(0, 64'h0, 0); exp_pend(32'h0);
      end_cycle();

      // scoreboard: issue r3, hold three cycles, writeback 0x55
      begin_cycle("sb_issue");
      iss = 1; ia = 3; set_ra(0, 3);
      exp_port(0, 64'h0, 0); exp_pend(32'h0);
      end_cycle();
      for (int c = 0; c < 3; c++) begin
         begin_cycle("sb_hold");
         set_ra(0, 3);
         exp_port(0, 64'h0, 1); exp_pend(32'h8);
         end_cycle();
      end
      begin_cycle("sb_wb");
      we = 1; wa = 3; wd = 64'h55; set_ra(0, 3);
      exp_port(0, 64'h55, 0); exp_pend(32'h8);
      end_cycle();
      begin_cycle("sb_done");
      set_ra(0, 3);
      exp_port(0, 64'h55, 0); exp_pend(32'h0);
      end_cycle();

      // issue and writeback to r3 together: issue wins
      begin_cycle("iss_wb");
      we = 1; wa = 3; wd = 64'h66; iss = 1; ia = 3; set_ra(0, 3); set_ra(1, 3);
      exp_port(0, 64'h66, 1); exp_port(1, 64'h66, 1); exp_pend(32'h0);
      end_cycle();
      begin_cycle("iss_wb_nx");
      set_ra(0, 3);
      exp_port(0, 64'h66, 1); exp_pend(32'h8);
      end_cycle();

      // flush plus issue r4: nothing pending afterwards
      begin_cycle("flush_iss");
      flush = 1; iss = 1; ia = 4; set_ra(0, 3); set_ra(1, 4);
      exp_port(0, 64'h66, 1); exp_port(1, 64'h0, 0); exp_pend(32'h8);
      end_cycle();
      begin_cycle("flush_nx");
      set_ra(0, 3); set_ra(1, 4);
      exp_port(0, 64'h66, 0); exp_port(1, 64'h0, 0); exp_pend(32'h0);
      end_cycle();

      // dirty the state before a mid-run reset
      begin_cycle("pre_rst_sp");
      we = 1; wa = 29; wd = 64'hAAAA; set_ra(0, 29);
      exp_port(0, 64'hAAAA, 0);
      end_cycle();
      begin_cycle("pre_rst_r5");
      we = 1; wa = 5; wd = 64'h77; iss = 1; ia = 6; set_ra(0, 5); set_ra(1, 6);
      exp_port(0, 64'h77, 0); exp_port(1, 64'h0, 0);
      end_cycle();
      begin_cycle("pre_rst_rd");
      set_ra(0, 29); set_ra(1, 6);
      exp_port(0, 64'hAAAA, 0); exp_port(1, 64'h0, 1); exp_pend(32'h40);
      end_cycle();

      // asynchronous reset with the clock stopped
      @(negedge clk);
      clk_en = 1'b0;
      we = 0; wa = 0; wd = 0; iss = 0; ia = 0; flush = 0;
      rd_addr = '0;
      set_ra(0, 29); set_ra(1, 5); set_ra(2, 6); set_ra(3, 7);
      #1 rst_n = 1'b0;
      model_reset();
      cur.name = "async_rst"; cur.dmask = '0; cur.bmask = '0;
      exp_port(0, 64'd124, 0); exp_port(1, 64'h0, 0);
      exp_port(2, 64'h0, 0);   exp_port(3, 64'h0, 0);
      exp_pend(32'h0);
      exp_q.push_back(cur);
      #1 -> sample_ev;
      #3 rst_n = 1'b1;
      #2 clk_en = 1'b1;

      // random run against the model
      for (int n = 0; n < 10000; n++) begin
         begin_cycle("random");
         we = 1'($urandom_range(0, 1));
         wa = pick();
         wd = {$urandom, $urandom};
         iss = ($urandom_range(0, 2) == 0);
         ia = ($urandom_range(0, 3) == 0) ? wa : pick();
         flush = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < NR; k++) set_ra(k, ($urandom_range(0, 3) == 0) ? wa : pick());
         model_expect();
         end_cycle();
      end

      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reg_file_sb
